// File: rtl/move_pulse_decoder.sv
// Turns well-formed 1,0,1,0,1,0 pulse bursts on four direction lines into move commands.
// Commands are buffered in a 2-entry queue behind valid/ready; malformed and dropped bursts are counted.

module move_pulse_decoder_line (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  output logic o_done,
  output logic o_err_entry
);

  typedef enum logic [2:0] {
    S_IDLE, S_H1, S_L1, S_H2, S_L2, S_H3, S_ERR
  } state_t;

  state_t r_state;
  logic   r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_in) r_state <= S_H1;
        S_H1:   r_state <= i_in ? S_ERR : S_L1;
        S_L1:   r_state <= i_in ? S_H2  : S_ERR;
        S_H2:   r_state <= i_in ? S_ERR : S_L2;
        S_L2:   r_state <= i_in ? S_H3  : S_ERR;
        S_H3: begin
          if (i_in) begin
            r_state <= S_ERR;
          end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_ERR:   if (!i_in) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Flags the edge that moves the FSM into ERR, so a stuck-high line counts once.
  always_comb begin
    o_err_entry = 1'b0;
    case (r_state)
      S_H1, S_H2, S_H3: o_err_entry = i_in;
      S_L1, S_L2:       o_err_entry = !i_in;
      default:          o_err_entry = 1'b0;
    endcase
  end

  assign o_done = r_done;

endmodule

module move_pulse_decoder #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             mv_ready,
  input  logic             clear_cnts,
  output logic             mv_valid,
  output logic [1:0]       mv_dir,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       Q_FULL  = 2'(FIFO_DEPTH);

  logic [3:0] w_btn;
  logic [3:0] w_done;
  logic [3:0] w_err;
  logic       w_win_vld;
  logic [1:0] w_win_dir;
  logic       w_pop;
  logic       w_push;
  logic       w_discard;
  logic [2:0] w_err_inc;
  logic [2:0] w_drop_inc;

  logic [1:0] r_mem [2];
  logic [1:0] r_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  assign w_btn = {btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_line
    move_pulse_decoder_line u_line (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in        (w_btn[g]),
      .o_done      (w_done[g]),
      .o_err_entry (w_err[g])
    );
  end

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [2:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    if (s[CNT_W]) return CNT_MAX;
    return s[CNT_W-1:0];
  endfunction

  // Lowest line index wins: up > down > left > right.
  always_comb begin
    w_win_dir = 2'd3;
    if (w_done[0])      w_win_dir = 2'd0;
    else if (w_done[1]) w_win_dir = 2'd1;
    else if (w_done[2]) w_win_dir = 2'd2;
  end

  assign w_win_vld  = |w_done;
  assign w_pop      = (r_cnt != 2'd0) && mv_ready;
  assign w_push     = w_win_vld && ((r_cnt != Q_FULL) || w_pop);
  assign w_discard  = w_win_vld && !w_push;
  assign w_err_inc  = pop4(w_err);
  assign w_drop_inc = pop4(w_done) - 3'(w_win_vld) + 3'(w_discard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= 2'd0;
      r_mem[1] <= 2'd0;
      r_cnt    <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem[0] <= w_win_dir;
          else               r_mem[1] <= w_win_dir;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem[0] <= r_mem[1];
          r_cnt    <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_mem[0] <= w_win_dir;
          end else begin
            r_mem[0] <= r_mem[1];
            r_mem[1] <= w_win_dir;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (clear_cnts) begin
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_err_cnt  <= sat_add(r_err_cnt, w_err_inc);
      r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
    end
  end

  assign mv_valid = (r_cnt != 2'd0);
  assign mv_dir   = r_mem[0];
  assign err_cnt  = r_err_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_move_pulse_decoder.sv
// Directed bench for move_pulse_decoder: inputs change and outputs are sampled 1ns after posedge.
module tb_move_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       mv_ready, clear_cnts;
  logic       mv_valid;
  logic [1:0] mv_dir;
  logic [7:0] err_cnt, drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  move_pulse_decoder #(.CNT_W(8), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .mv_ready   (mv_ready),
    .clear_cnts (clear_cnts),
    .mv_valid   (mv_valid),
    .mv_dir     (mv_dir),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v bit order: 0=up, 1=down, 2=left, 3=right
  task automatic set_btn(input logic [3:0] v);
    {btn_right, btn_left, btn_down, btn_up} = v;
  endtask

  task automatic burst(input logic [3:0] mask);
    for (int t = 0; t < 6; t++) begin
      set_btn((t % 2 == 0) ? mask : 4'b0000);
      tick();
    end
    set_btn(4'b0000);
  endtask

  task automatic clr();
    clear_cnts = 1'b1;
    tick();
    clear_cnts = 1'b0;
  endtask

  function automatic logic legal(input int t);
    return (t >= 0) && (t < 6) && ((t % 2) == 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    set_btn(4'b0000);
    mv_ready = 1'b0;
    clear_cnts = 1'b0;
    #12;
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", mv_valid); else n_pass++;
    n_checks++; if (mv_dir !== 2'b00) $display("FAIL reset_dir: got %b want 00", mv_dir); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_left();
    mv_ready = 1'b1;
    clr();
    burst(4'b0100);
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL single_latency: got %b want 0", mv_valid); else n_pass++;
    tick();
    n_checks++; if (mv_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", mv_valid); else n_pass++;
    n_checks++; if (mv_dir !== 2'b10) $display("FAIL single_dir: got %b want 10", mv_dir); else n_pass++;
    tick();
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL single_popped: got %b want 0", mv_valid); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL single_err: got %0d want 0", err_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL single_drop: got %0d want 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_arbitration();
    mv_ready = 1'b1;
    clr();
    burst(4'b1001);
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL arb_drop_early: got %0d want 0", drop_cnt); else n_pass++;
    tick();
    n_checks++; if (mv_valid !== 1'b1) $display("FAIL arb_valid: got %b want 1", mv_valid); else n_pass++;
    n_checks++; if (mv_dir !== 2'b00) $display("FAIL arb_dir: got %b want 00", mv_dir); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd1) $display("FAIL arb_drop: got %0d want 1", drop_cnt); else n_pass++;
    tick();
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL arb_single_cmd: got %b want 0", mv_valid); else n_pass++;
  endtask

  task automatic test_fifo_full();
    int accepts;
    mv_ready = 1'b0;
    clr();
    burst(4'b0010);
    tick();
    n_checks++; if (mv_valid !== 1'b1) $display("FAIL full_valid1: got %b want 1", mv_valid); else n_pass++;
    n_checks++; if (mv_dir !== 2'b01) $display("FAIL full_dir1: got %b want 01", mv_dir); else n_pass++;
    burst(4'b0010);
    tick();
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL full_drop2: got %0d want 0", drop_cnt); else n_pass++;
    burst(4'b0010);
    tick();
    n_checks++; if (drop_cnt !== 8'd1) $display("FAIL full_drop3: got %0d want 1", drop_cnt); else n_pass++;
    n_checks++; if (mv_dir !== 2'b01) $display("FAIL full_dir_hold: got %b want 01", mv_dir); else n_pass++;
    mv_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      if (mv_valid === 1'b1) accepts++;
      tick();
    end
    n_checks++; if (accepts != 2) $display("FAIL full_accepts: got %0d want 2", accepts); else n_pass++;
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL full_drained: got %b want 0", mv_valid); else n_pass++;
  endtask

  task automatic test_long_high();
    logic saw_valid;
    mv_ready = 1'b1;
    clr();
    saw_valid = 1'b0;
    set_btn(4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mv_valid === 1'b1) saw_valid = 1'b1;
    end
    set_btn(4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mv_valid === 1'b1) saw_valid = 1'b1;
    end
    n_checks++; if (err_cnt !== 8'd1) $display("FAIL long_err: got %0d want 1", err_cnt); else n_pass++;
    n_checks++; if (saw_valid !== 1'b0) $display("FAIL long_no_cmd: got %b want 0", saw_valid); else n_pass++;
    burst(4'b0001);
    tick();
    n_checks++; if (mv_valid !== 1'b1) $display("FAIL long_next_valid: got %b want 1", mv_valid); else n_pass++;
    n_checks++; if (mv_dir !== 2'b00) $display("FAIL long_next_dir: got %b want 00", mv_dir); else n_pass++;
    tick();
  endtask

  task automatic test_truncated_saturate();
    logic [3:0] seq [5];
    mv_ready = 1'b1;
    clr();
    seq = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      set_btn(seq[i]);
      tick();
    end
    n_checks++; if (err_cnt !== 8'd1) $display("FAIL trunc_err: got %0d want 1", err_cnt); else n_pass++;
    tick();
    for (int i = 0; i < 300; i++) begin
      set_btn(4'b1000);
      tick();
      tick();
      set_btn(4'b0000);
      tick();
    end
    n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_err: got %0d want 255", err_cnt); else n_pass++;
    set_btn(4'b1000);
    tick();
    clear_cnts = 1'b1;
    tick();
    clear_cnts = 1'b0;
    set_btn(4'b0000);
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL clear_prio: got %0d want 0", err_cnt); else n_pass++;
    tick();
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL clear_hold: got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    mv_ready = 1'b1;
    clr();
    for (int t = 0; t < 8; t++) begin
      set_btn({2'b00, legal(t - 1), legal(t)});
      tick();
      if (t == 6) begin
        n_checks++; if (mv_dir !== 2'b00 || mv_valid !== 1'b1) $display("FAIL b2b_first: got v=%b d=%b want v=1 d=00", mv_valid, mv_dir); else n_pass++;
      end
      if (t == 7) begin
        n_checks++; if (mv_dir !== 2'b01 || mv_valid !== 1'b1) $display("FAIL b2b_second: got v=%b d=%b want v=1 d=01", mv_valid, mv_dir); else n_pass++;
      end
    end
    set_btn(4'b0000);
    tick();
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", mv_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL b2b_drop: got %0d want 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    mv_ready = 1'b0;
    clr();
    burst(4'b1000);
    tick();
    set_btn(4'b0001);
    tick();
    tick();
    set_btn(4'b0000);
    tick();
    set_btn(4'b0100); tick();
    set_btn(4'b0000); tick();
    set_btn(4'b0100); tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", mv_valid); else n_pass++;
    n_checks++; if (mv_dir !== 2'b00) $display("FAIL rst_mid_dir: got %b want 00", mv_dir); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL rst_mid_err: got %0d want 0", err_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rst_mid_drop: got %0d want 0", drop_cnt); else n_pass++;
    set_btn(4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_btn(4'b0100); tick();
    set_btn(4'b0000); tick();
    tick();
    tick();
    n_checks++; if (err_cnt !== 8'd1) $display("FAIL rst_fragment_err: got %0d want 1", err_cnt); else n_pass++;
    n_checks++; if (mv_valid !== 1'b0) $display("FAIL rst_fifo_empty: got %b want 0", mv_valid); else n_pass++;
    mv_ready = 1'b1;
    burst(4'b0100);
    tick();
    n_checks++; if (mv_valid !== 1'b1 || mv_dir !== 2'b10) $display("FAIL rst_next_burst: got v=%b d=%b want v=1 d=10", mv_valid, mv_dir); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_left();
    test_arbitration();
    test_fifo_full();
    test_long_high();
    test_truncated_saturate();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
